fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-register PC/next-PC mux of the single-cycle core. It owns the fetch PC and issues in-order requests to instruction memory over a ready/valid handshake. It buffers returned instructions with their PCs in a FIFO_DEPTH-entry prefetch queue and presents them to decode with a valid/ready handshake. Taken branches and jumps from execute redirect the fetch PC, flush the queue and discard any in-flight responses.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem requests,
// and buffers returned words with their PCs in a small prefetch queue for decode.
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0100_0000,
    parameter int              FIFO_DEPTH   = 4,
    parameter int              CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W:0]  DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [XLEN-1:0]  data_q [FIFO_DEPTH];
    logic [XLEN-1:0]  pc_q   [FIFO_DEPTH];

    logic [CNT_W:0]   occupancy;
    logic [XLEN-1:0]  target;
    logic             req_fire, rsp_ok, push, pop;

    // Queued plus in-flight words never exceed the queue size, so a response always has a slot.
    assign occupancy      = {1'b0, count_q} + {1'b0, in_flight_q};
    assign imem_req_valid = reset_n && !redirect_valid && (occupancy < DEPTH_L);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_ok         = imem_rsp_valid && (in_flight_q != '0);
    assign push           = rsp_ok && !redirect_valid && (drop_q == '0);
    assign inst_valid     = (count_q != '0);
    assign pop            = inst_valid && inst_ready;
    assign inst_data      = data_q[rd_ptr_q];
    assign inst_pc        = pc_q[rd_ptr_q];
    assign target         = redirect_pc & ~XLEN'(3);

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        drop_d      = drop_q;
        in_flight_d = in_flight_q + CNT_W'(req_fire) - CNT_W'(rsp_ok);
        if (redirect_valid) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            fetch_pc_d = target;
            rsp_pc_d   = target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_d     = in_flight_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (rsp_ok) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + STEP;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q  <= RESET_VECTOR;
            rsp_pc_q    <= RESET_VECTOR;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            in_flight_q <= '0;
            drop_q      <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            in_flight_q <= in_flight_d;
            drop_q      <= drop_d;
        end
    end

    // Entries are cleared on reset so the head reads as zero while the queue is empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= imem_rsp_data;
            pc_q[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an imem model with configurable latency plus an in-order
// stream model (expected next PC / next request address) checked on every handshake.
module tb_fetch_unit;

    localparam logic [31:0] RV = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;

    fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    typedef struct {
        logic [31:0] tgt;
        int          lat;
        logic [31:0] exp_first;
        logic [31:0] exp_second;
    } vec_t;

    rsp_t        mq[$];
    int          tests = 0, fails = 0;
    int          cyc = 0, last_due = 0, lat_min = 1, lat_max = 1, pops = 0, n_since = 0;
    bit          rdy_rand = 0, irdy_rand = 0, spurious_en = 0, redir_prev = 0, got_first = 0;
    logic [31:0] exp_pc, exp_req, first_pc;
    logic [31:0] since_pc[2];
    logic        s_req_valid, s_inst_valid, s_acc, s_pop;
    logic [31:0] s_req_addr, s_inst_pc, s_inst_data;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One clock cycle: observe at negedge, update models, drive next inputs after posedge.
    task automatic tick();
        int lat, due;
        @(negedge clk);
        s_req_valid  = imem_req_valid;
        s_req_addr   = imem_req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_inst_data  = inst_data;
        s_acc        = imem_req_valid && imem_req_ready;
        s_pop        = inst_valid && inst_ready;
        if (redir_prev) check("valid_after_redirect", {31'b0, s_inst_valid}, 32'd0);
        if (s_pop) begin
            $display("[TB] pop pc=%h data=%h", s_inst_pc, s_inst_data);
            check("inst_pc", s_inst_pc, exp_pc);
            check("inst_data", s_inst_data, word_of(exp_pc));
            if (!got_first) begin
                got_first = 1;
                first_pc  = s_inst_pc;
            end
            if (n_since < 2) since_pc[n_since] = s_inst_pc;
            n_since++;
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (s_acc) begin
            check("req_addr", s_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
        end
        redir_prev = redirect_valid;
        if (redirect_valid) begin
            exp_pc    = redirect_pc & ~32'd3;
            exp_req   = redirect_pc & ~32'd3;
            got_first = 0;
            n_since   = 0;
        end
        @(posedge clk);
        #1;
        if (s_acc) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: s_req_addr, due: due});
        end
        cyc++;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mq[0].addr);
            void'(mq.pop_front());
        end else if (spurious_en && mq.size() == 0 && $urandom_range(7, 0) == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        redirect_valid = 1'b0;
        imem_req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        if (irdy_rand) inst_ready = 1'($urandom_range(1, 0));
    endtask

    // Entered just after a posedge; asserts reset between edges and releases between edges.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, RV);
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n    = 1'b1;
        last_due   = cyc;
        exp_pc     = RV;
        exp_req    = RV;
        got_first  = 0;
        n_since    = 0;
        redir_prev = 0;
    endtask

    task automatic wait_pops(input int n, input int bound);
        for (int i = 0; i < bound && n_since < n; i++) tick();
    endtask

    initial begin
        vec_t vecs[5];
        int   p0, accs, fv;
        bit   sawreq;
        logic [31:0] fpc;

        vecs[0] = '{tgt: 32'h0100_0107, lat: 1, exp_first: 32'h0100_0104, exp_second: 32'h0100_0108};
        vecs[1] = '{tgt: 32'h0100_0100, lat: 2, exp_first: 32'h0100_0100, exp_second: 32'h0100_0104};
        vecs[2] = '{tgt: 32'h0000_0002, lat: 3, exp_first: 32'h0000_0000, exp_second: 32'h0000_0004};
        vecs[3] = '{tgt: 32'hFFFF_FFFE, lat: 1, exp_first: 32'hFFFF_FFFC, exp_second: 32'h0000_0000};
        vecs[4] = '{tgt: 32'h8000_0005, lat: 2, exp_first: 32'h8000_0004, exp_second: 32'h8000_0008};

        reset_n        = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;

        // Streaming from reset with a 1-cycle memory.
        do_reset();
        p0 = pops;
        fv = -1;
        fpc = 32'h0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c == 0) begin
                check("first_req_valid", {31'b0, s_req_valid}, 32'd1);
                check("first_req_addr", s_req_addr, RV);
            end
            if (s_inst_valid && fv < 0) begin
                fv  = c;
                fpc = s_inst_pc;
            end
        end
        check("first_valid_cycle", 32'(fv), 32'd2);
        check("first_valid_pc", fpc, RV);
        check("stream_throughput", 32'(pops - p0), 32'd10);

        // Decode stalled: issue stops at four outstanding words.
        inst_ready = 1'b0;
        do_reset();
        accs = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            accs += int'(s_acc);
        end
        check("bp_accepts", 32'(accs), 32'd4);
        check("bp_req_blocked", {31'b0, s_req_valid}, 32'd0);
        check("bp_head_valid", {31'b0, s_inst_valid}, 32'd1);
        inst_ready = 1'b1;
        p0 = pops;
        sawreq = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            sawreq |= s_req_valid;
        end
        check("bp_drain_pops", 32'(pops - p0), 32'd6);
        check("bp_reissue", {31'b0, sawreq}, 32'd1);

        // Redirect with words both queued and in flight; head pops in the redirect cycle.
        lat_min = 3; lat_max = 3;
        inst_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 5; c++) tick();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0100;
        tick();
        check("pop_in_redirect", {31'b0, s_pop}, 32'd1);
        wait_pops(1, 30);
        check("redir_got_inst", {31'b0, got_first}, 32'd1);
        check("redir_first_pc", first_pc, 32'h0100_0100);

        // Redirect coinciding with a response, then a second redirect while drops are pending.
        lat_min = 4; lat_max = 4;
        do_reset();
        for (int c = 0; c < 4; c++) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0180;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0200;
        tick();
        wait_pops(1, 40);
        check("redir2_got_inst", {31'b0, got_first}, 32'd1);
        check("redir2_first_pc", first_pc, 32'h0100_0200);

        // Table of redirect targets: alignment and address wrap.
        foreach (vecs[i]) begin
            lat_min = vecs[i].lat;
            lat_max = vecs[i].lat;
            redirect_valid = 1'b1;
            redirect_pc    = vecs[i].tgt;
            tick();
            wait_pops(2, 40);
            check("vec_pop_count", 32'(n_since), 32'd2);
            check("vec_first_pc", since_pc[0], vecs[i].exp_first);
            check("vec_second_pc", since_pc[1], vecs[i].exp_second);
        end

        // Asynchronous reset mid-stream.
        lat_min = 1; lat_max = 1;
        for (int c = 0; c < 4; c++) tick();
        check("pre_reset_valid", {31'b0, s_inst_valid}, 32'd1);
        do_reset();
        tick();
        check("post_reset_req_valid", {31'b0, s_req_valid}, 32'd1);
        check("post_reset_req_addr", s_req_addr, RV);
        wait_pops(1, 10);
        check("post_reset_first_pc", first_pc, RV);

        // Randomized traffic: random handshakes, latencies, redirects and stray responses.
        lat_min = 1; lat_max = 3;
        rdy_rand = 1; irdy_rand = 1; spurious_en = 1;
        p0 = pops;
        for (int c = 0; c < 1500; c++) begin
            if (!redir_prev && $urandom_range(15, 0) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = RV + 32'($urandom_range(4095, 0));
            end
            tick();
        end
        check("random_progress", {31'b0, (pops - p0) > 100}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
